// File: rtl/legv8_seq_ctrl_pkg.sv
// Shared constants for the LEGv8 sequencer: opcodes, ALU function codes, FSM states and
// ControlWord field offsets.
package legv8_ctrl_pkg;

  localparam logic [10:0] OpAdd  = 11'b10001011000;
  localparam logic [10:0] OpSub  = 11'b11001011000;
  localparam logic [10:0] OpAnd  = 11'b10001010000;
  localparam logic [10:0] OpOrr  = 11'b10101010000;
  localparam logic [10:0] OpLdur = 11'b11111000010;
  localparam logic [10:0] OpStur = 11'b11111000000;
  localparam logic [9:0]  OpAddi = 10'b1001000100;
  localparam logic [9:0]  OpSubi = 10'b1101000100;
  localparam logic [8:0]  OpMovz = 9'b110100101;
  localparam logic [7:0]  OpCbz  = 8'b10110100;
  localparam logic [7:0]  OpCbnz = 8'b10110101;
  localparam logic [5:0]  OpB    = 6'b000101;

  localparam logic [4:0] FsAdd = 5'b01000;
  localparam logic [4:0] FsSub = 5'b01011;
  localparam logic [4:0] FsAnd = 5'b00000;
  localparam logic [4:0] FsOrr = 5'b00100;

  localparam logic [4:0] Xzr = 5'd31;

  localparam int unsigned CwWidth = 25;
  localparam int unsigned CwSa    = 20;
  localparam int unsigned CwSb    = 15;
  localparam int unsigned CwDa    = 10;
  localparam int unsigned CwRw    = 9;
  localparam int unsigned CwMw    = 8;
  localparam int unsigned CwFs    = 3;
  localparam int unsigned CwBsel  = 2;
  localparam int unsigned CwEnMem = 1;
  localparam int unsigned CwEnAlu = 0;

  typedef enum logic [1:0] {
    StFetch,
    StDecode,
    StExec,
    StHalt
  } state_e;

endpackage

// File: rtl/legv8_seq_ctrl_if.sv
// Instruction-memory request/acknowledge port of the LEGv8 sequencer.
interface legv8_seq_ctrl_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/legv8_decoder.sv
// Combinational LEGv8 subset decoder: instruction word to ControlWord, constant and branch
// flags. Branch opcodes are decoded only when LEGV8_CTRL_BRANCH_EN is defined.
module legv8_decoder
  import legv8_ctrl_pkg::*;
(
  input  logic [31:0]        ir,
  output logic [CwWidth-1:0] control_word,
  output logic [63:0]        constant,
  output logic               is_branch,
  output logic               is_cond,
  output logic               cond_nz,
  output logic               illegal
);

  logic [4:0]  sa, sb, da, fs;
  logic        reg_write, mem_write, bsel, en_mem, en_alu;
  logic [4:0]  rd, rn, rm;
  logic [11:0] imm12;
  logic [8:0]  addr9;
  logic [15:0] imm16;
  logic [1:0]  hw;

  assign rd    = ir[4:0];
  assign rn    = ir[9:5];
  assign rm    = ir[20:16];
  assign imm12 = ir[21:10];
  assign addr9 = ir[20:12];
  assign imm16 = ir[20:5];
  assign hw    = ir[22:21];

  always_comb begin
    sa        = '0;
    sb        = '0;
    da        = '0;
    fs        = FsAdd;
    reg_write = 1'b0;
    mem_write = 1'b0;
    bsel      = 1'b0;
    en_mem    = 1'b0;
    en_alu    = 1'b0;
    constant  = '0;
    is_branch = 1'b0;
    is_cond   = 1'b0;
    cond_nz   = 1'b0;
    illegal   = 1'b0;

    if (ir[31:21] == OpAdd || ir[31:21] == OpSub ||
        ir[31:21] == OpAnd || ir[31:21] == OpOrr) begin
      sa        = rn;
      sb        = rm;
      da        = rd;
      en_alu    = 1'b1;
      reg_write = 1'b1;
      if (ir[31:21] == OpSub)      fs = FsSub;
      else if (ir[31:21] == OpAnd) fs = FsAnd;
      else if (ir[31:21] == OpOrr) fs = FsOrr;
      else                         fs = FsAdd;
    end else if (ir[31:22] == OpAddi || ir[31:22] == OpSubi) begin
      sa        = rn;
      sb        = rm;
      da        = rd;
      bsel      = 1'b1;
      en_alu    = 1'b1;
      reg_write = 1'b1;
      fs        = (ir[31:22] == OpSubi) ? FsSub : FsAdd;
      constant  = {52'd0, imm12};
    end else if (ir[31:21] == OpLdur) begin
      sa        = rn;
      da        = rd;
      bsel      = 1'b1;
      en_mem    = 1'b1;
      reg_write = 1'b1;
      constant  = {{55{addr9[8]}}, addr9};
    end else if (ir[31:21] == OpStur) begin
      sa        = rn;
      sb        = rd;
      bsel      = 1'b1;
      mem_write = 1'b1;
      constant  = {{55{addr9[8]}}, addr9};
    end else if (ir[31:23] == OpMovz) begin
      sa        = Xzr;
      da        = rd;
      bsel      = 1'b1;
      fs        = FsOrr;
      en_alu    = 1'b1;
      reg_write = 1'b1;
      constant  = {48'd0, imm16} << {hw, 4'b0000};
    end else if (ir[31:24] == OpCbz || ir[31:24] == OpCbnz) begin
`ifdef LEGV8_CTRL_BRANCH_EN
      sa      = Xzr;
      sb      = rd;
      is_cond = 1'b1;
      cond_nz = ir[24];
`else
      illegal = 1'b1;
`endif
    end else if (ir[31:26] == OpB) begin
`ifdef LEGV8_CTRL_BRANCH_EN
      is_branch = 1'b1;
`else
      illegal = 1'b1;
`endif
    end else begin
      illegal = 1'b1;
    end
  end

  assign control_word = {sa, sb, da, reg_write, mem_write, fs, bsel, en_mem, en_alu};

endmodule

// File: rtl/legv8_seq_ctrl.sv
// Multi-cycle LEGv8 sequencer: FETCH/DECODE/EXEC/HALT FSM, pc, IR and registered datapath
// controls. Define LEGV8_CTRL_BRANCH_EN to enable B/CBZ/CBNZ.
module legv8_seq_ctrl
  import legv8_ctrl_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic               clock,
  input  logic               reset,
  legv8_seq_ctrl_if.master   imem,
  input  logic [3:0]         status,
  output logic [CwWidth-1:0] ControlWord,
  output logic [63:0]        constant,
  output logic [63:0]        pc,
  output logic               retire,
  output logic               halted
);

  state_e              state_q, state_d;
  logic [63:0]         pc_q, pc_d, pc_next;
  logic [31:0]         ir_q, ir_d;
  logic [CwWidth-1:0]  cw_q, cw_d, dec_cw;
  logic [63:0]         const_q, const_d, dec_const;
  logic                is_branch, is_cond, cond_nz, illegal;

  legv8_decoder u_decoder (
    .ir           (ir_q),
    .control_word (dec_cw),
    .constant     (dec_const),
    .is_branch    (is_branch),
    .is_cond      (is_cond),
    .cond_nz      (cond_nz),
    .illegal      (illegal)
  );

`ifdef LEGV8_CTRL_BRANCH_EN
  logic        taken;
  logic [63:0] offset;
  logic        unused_status;

  assign unused_status = ^status[3:1];

  // CBZ takes on Z=1, CBNZ on Z=0; IR is stable through EXEC so decode flags are live.
  always_comb begin
    taken   = is_branch | (is_cond & (status[0] ^ cond_nz));
    offset  = is_branch ? {{38{ir_q[25]}}, ir_q[25:0]} : {{45{ir_q[23]}}, ir_q[23:5]};
    pc_next = taken ? (pc_q + (offset << 2)) : (pc_q + 64'd4);
  end
`else
  logic unused_branch;

  assign unused_branch = ^{status, is_branch, is_cond, cond_nz};
  assign pc_next       = pc_q + 64'd4;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cw_d    = cw_q;
    const_d = const_q;
    unique case (state_q)
      StFetch: begin
        if (imem.imem_ack) begin
          ir_d    = imem.imem_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (illegal) begin
          state_d = StHalt;
        end else begin
          cw_d    = dec_cw;
          const_d = dec_const;
          state_d = StExec;
        end
      end
      StExec: begin
        pc_d    = pc_next;
        cw_d    = '0;
        state_d = StFetch;
      end
      StHalt: begin
        cw_d = '0;
      end
      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      cw_q    <= '0;
      const_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cw_q    <= cw_d;
      const_q <= const_d;
    end
  end

  // Reset is synchronous, so mask the registered outputs during the reset cycle itself.
  assign imem.imem_req  = (state_q == StFetch) && !reset;
  assign imem.imem_addr = pc_q;
  assign ControlWord    = reset ? '0 : cw_q;
  assign retire         = (state_q == StExec) && !reset;
  assign halted         = (state_q == StHalt);
  assign constant       = const_q;
  assign pc             = pc_q;

endmodule

// File: tb/tb_legv8_seq_ctrl.sv
// Directed self-checking bench for legv8_seq_ctrl; follows LEGV8_CTRL_BRANCH_EN if defined.
module tb_legv8_seq_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  status;
  logic [24:0] ControlWord;
  logic [63:0] constant;
  logic [63:0] pc;
  logic        retire;
  logic        halted;
  logic [63:0] pcx;
  int          total = 0;
  int          bad   = 0;

  localparam logic [4:0] FADD = 5'b01000;
  localparam logic [4:0] FSUB = 5'b01011;
  localparam logic [4:0] FORR = 5'b00100;

  legv8_seq_ctrl_if imem_bus ();

  legv8_seq_ctrl #(
    .RESET_PC (64'h0)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .imem        (imem_bus),
    .status      (status),
    .ControlWord (ControlWord),
    .constant    (constant),
    .pc          (pc),
    .retire      (retire),
    .halted      (halted)
  );

  always #5 clock = ~clock;

  function automatic logic [24:0] mkcw(input logic [4:0] sa, input logic [4:0] sb,
                                       input logic [4:0] da, input logic rw, input logic mw,
                                       input logic [4:0] fs, input logic bs, input logic em,
                                       input logic ea);
    return {sa, sb, da, rw, mw, fs, bs, em, ea};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leaves the DUT one cycle after DECODE (EXEC, or HALT for an illegal word).
  task automatic run(input logic [31:0] instr, input int waits);
    for (int i = 0; i < waits; i++) begin
      imem_bus.imem_ack = 1'b0;
      tick();
      chk("wait_req", {63'd0, imem_bus.imem_req}, 64'd1);
    end
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = instr;
    tick();
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    chk("decode_cw_zero", {39'd0, ControlWord}, 64'd0);
    chk("decode_req_low", {63'd0, imem_bus.imem_req}, 64'd0);
    tick();
  endtask

  task automatic finish_exec(input string tag, input logic [63:0] next_pc);
    chk({tag, "_retire"}, {63'd0, retire}, 64'd1);
    chk({tag, "_pc_hold"}, pc, pcx);
    tick();
    pcx = next_pc;
    chk({tag, "_pc_next"}, pc, pcx);
    chk({tag, "_cw_clear"}, {39'd0, ControlWord}, 64'd0);
    chk({tag, "_addr"}, imem_bus.imem_addr, pcx);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    pcx = 64'h0;
  endtask

  initial begin
    reset = 1'b1;
    status = 4'h0;
    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    pcx = 64'h0;
    tick();
    tick();
    chk("rst_req", {63'd0, imem_bus.imem_req}, 64'd0);
    chk("rst_pc", pc, 64'h0);
    chk("rst_cw", {39'd0, ControlWord}, 64'd0);
    chk("rst_const", constant, 64'd0);
    chk("rst_retire", {63'd0, retire}, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    reset = 1'b0;
    #1;
    chk("fetch_req", {63'd0, imem_bus.imem_req}, 64'd1);

    run(32'h910017E1, 0);
    chk("addi_cw", {39'd0, ControlWord}, {39'd0, mkcw(5'd31, 5'd0, 5'd1, 1, 0, FADD, 1, 0, 1)});
    chk("addi_const", constant, 64'd5);
    finish_exec("addi", 64'h4);

    run({11'b11111000010, 9'h1F8, 2'b00, 5'd1, 5'd2}, 2);
    chk("ldur_cw", {39'd0, ControlWord}, {39'd0, mkcw(5'd1, 5'd0, 5'd2, 1, 0, FADD, 1, 1, 0)});
    chk("ldur_const", constant, 64'hFFFF_FFFF_FFFF_FFF8);
    finish_exec("ldur", 64'h8);

    run({11'b11111000000, 9'h000, 2'b00, 5'd1, 5'd2}, 1);
    chk("stur_cw", {39'd0, ControlWord}, {39'd0, mkcw(5'd1, 5'd2, 5'd0, 0, 1, FADD, 1, 0, 0)});
    chk("stur_const", constant, 64'd0);
    finish_exec("stur", 64'hC);

    run({9'b110100101, 2'd1, 16'h1234, 5'd5}, 0);
    chk("movz_cw", {39'd0, ControlWord}, {39'd0, mkcw(5'd31, 5'd0, 5'd5, 1, 0, FORR, 1, 0, 1)});
    chk("movz_const", constant, 64'h0000_0000_1234_0000);
    finish_exec("movz", 64'h10);

`ifdef LEGV8_CTRL_BRANCH_EN
    status = 4'b0001;
    run({8'b10110100, 19'd3, 5'd3}, 0);
    chk("cbz_cw", {39'd0, ControlWord}, {39'd0, mkcw(5'd31, 5'd3, 5'd0, 0, 0, FADD, 0, 0, 0)});
    finish_exec("cbz_taken", 64'h1C);
    run({8'b10110101, 19'd5, 5'd3}, 1);
    finish_exec("cbnz_not_taken", 64'h20);
    status = 4'b0000;
`else
    status = 4'b0001;
    run({8'b10110100, 19'd3, 5'd3}, 0);
    chk("cbz_halted", {63'd0, halted}, 64'd1);
    chk("cbz_halt_req", {63'd0, imem_bus.imem_req}, 64'd0);
    chk("cbz_halt_pc", pc, 64'h10);
    status = 4'b0000;
    do_reset();
    chk("cbz_rst_halted", {63'd0, halted}, 64'd0);
`endif

    run({11'b10101010000, 5'd2, 6'd0, 5'd1, 5'd4}, 0);
    chk("orr_cw", {39'd0, ControlWord}, {39'd0, mkcw(5'd1, 5'd2, 5'd4, 1, 0, FORR, 0, 0, 1)});
    finish_exec("orr", pcx + 64'd4);

    run({10'b1101000100, 12'd1, 5'd1, 5'd6}, 0);
    chk("subi_cw", {39'd0, ControlWord}, {39'd0, mkcw(5'd1, 5'd0, 5'd6, 1, 0, FSUB, 1, 0, 1)});
    chk("subi_const", constant, 64'd1);
    finish_exec("subi", pcx + 64'd4);

    // Reset in the second wait cycle of a stalled fetch.
    chk("midfetch_pc_nonzero", {63'd0, (pc != 64'h0)}, 64'd1);
    imem_bus.imem_ack = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("midfetch_rst_req", {63'd0, imem_bus.imem_req}, 64'd0);
    tick();
    reset = 1'b0;
    #1;
    pcx = 64'h0;
    chk("midfetch_pc", pc, 64'h0);
    chk("midfetch_cw", {39'd0, ControlWord}, 64'd0);
    chk("midfetch_req", {63'd0, imem_bus.imem_req}, 64'd1);
    run(32'h910017E1, 0);
    chk("restart_cw", {39'd0, ControlWord}, {39'd0, mkcw(5'd31, 5'd0, 5'd1, 1, 0, FADD, 1, 0, 1)});
    finish_exec("restart", 64'h4);

    // Reset during EXEC: outputs cleared in that cycle and pc does not advance.
    run({11'b11111000010, 9'h1F8, 2'b00, 5'd1, 5'd2}, 1);
    chk("exrst_cw_before", {39'd0, ControlWord},
        {39'd0, mkcw(5'd1, 5'd0, 5'd2, 1, 0, FADD, 1, 1, 0)});
    reset = 1'b1;
    #1;
    chk("exrst_cw", {39'd0, ControlWord}, 64'd0);
    chk("exrst_retire", {63'd0, retire}, 64'd0);
    tick();
    reset = 1'b0;
    #1;
    pcx = 64'h0;
    chk("exrst_pc", pc, 64'h0);
    chk("exrst_cw_after", {39'd0, ControlWord}, 64'd0);

`ifdef LEGV8_CTRL_BRANCH_EN
    status = 4'b1110;
    run({8'b10110100, 19'd3, 5'd3}, 0);
    finish_exec("cbz_not_taken", 64'h4);
    do_reset();
    run({6'b000101, 26'h3FF_FFFF}, 0);
    finish_exec("b_back", 64'hFFFF_FFFF_FFFF_FFFC);
    run(32'h910017E1, 0);
    finish_exec("wrap", 64'h0);
    status = 4'b0000;
`endif

    do_reset();
    run(32'h0, 0);
    chk("halt_flag", {63'd0, halted}, 64'd1);
    chk("halt_req", {63'd0, imem_bus.imem_req}, 64'd0);
    chk("halt_cw", {39'd0, ControlWord}, 64'd0);
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = 32'h910017E1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_sticky", {63'd0, halted}, 64'd1);
      chk("halt_no_retire", {63'd0, retire}, 64'd0);
      chk("halt_pc", pc, 64'h0);
    end
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    do_reset();
    chk("halt_exit", {63'd0, halted}, 64'd0);
    chk("halt_exit_req", {63'd0, imem_bus.imem_req}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/legv8_seq_ctrl.md
# legv8_seq_ctrl

Multi-cycle sequencer for the LEGv8 datapath. Holds the PC, fetches 32-bit instructions over a request/acknowledge port, decodes a LEGv8 subset, and drives the 25-bit datapath control word, constant and branch decisions for one instruction at a time. Sits between instruction memory and the datapath; consumes the datapath's 4-bit status.

## Interface
Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; takes effect at the next rising edge of clock.
- imem_req  out  1  fetch request; held high in FETCH until acknowledged.
- imem_addr  out  64  equals pc.
- imem_ack  in  1  rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- status  in  4  datapath flags {V,C,N,Z}; Z is bit 0.
- ControlWord  out  25  {SA[4:0],SB[4:0],DA[4:0],RegWrite,MemWrite,FS[4:0],Bsel,EN_Mem,EN_ALU}, MSB first.
- constant  out  64  immediate for the datapath B mux.
- pc  out  64  current program counter.
- retire  out  1  high during the EXEC cycle of each instruction.
- halted  out  1  sticky; set on an unsupported opcode.

## Operation
- States: FETCH, DECODE, EXEC, HALT. Reset: state=FETCH, pc=RESET_PC, IR=0, ControlWord=0, constant=0, imem_req=0 for the reset cycle, retire=0, halted=0.
- FETCH: imem_req=1. On imem_ack, latch imem_rdata into IR and go to DECODE. An ack arriving in the same cycle as the first req is legal.
- DECODE: compute the next ControlWord and constant from IR into output registers, then go to EXEC. An unsupported opcode goes to HALT instead.
- EXEC: outputs are driven and retire=1. At the end of the cycle, RegWrite/MemWrite commit in the datapath and pc updates. Then ControlWord is cleared to 0 and the state returns to FETCH.
- HALT: ControlWord=0, imem_req=0, halted=1. The only exit is reset.
- Register 31 is XZR (reads 0).
- Field extraction: Rd/Rt=[4:0], Rn=[9:5], Rm=[20:16], imm12=[21:10] (zero-extended), addr9=[20:12] (sign-extended), imm16=[20:5], hw=[22:21], br26=[25:0], cb19=[23:5].
- FS codes: ADD=5'b01000, SUB=5'b01011, AND=5'b00000, ORR=5'b00100.
- ADD/SUB/AND/ORR (R-type): SA=Rn, SB=Rm, DA=Rd, Bsel=0, EN_ALU=1, RegWrite=1.
- ADDI/SUBI: as R-type, but Bsel=1, constant=imm12.
- LDUR: SA=Rn, Bsel=1, constant=sext(addr9), FS=ADD, EN_Mem=1, DA=Rt, RegWrite=1.
- STUR: SA=Rn, SB=Rt, Bsel=1, constant=sext(addr9), FS=ADD, MemWrite=1, both enables 0.
- MOVZ: SA=31, Bsel=1, constant=imm16<<(16*hw), FS=ORR, EN_ALU=1, RegWrite=1, DA=Rd.
- CBZ/CBNZ: SA=31, SB=Rt, Bsel=0, FS=ADD, no writes, no enables. Sample status[0] at the end of EXEC.
- PC update: taken branch gives pc+(sext(offset)<<2); otherwise pc+4. Arithmetic is modulo 2^64; wrap-around is permitted with no flag.

## Timing
- Minimum 3 cycles per instruction: FETCH(1+wait), DECODE, EXEC.
- ControlWord is registered. It is nonzero only during EXEC, so the data bus is undriven in all other cycles.
- pc changes only at the EXEC→FETCH edge.
- reset during any state, including mid-fetch with imem_req high, discards IR and pending writes. In the reset cycle itself, ControlWord=0.
- imem_ack outside FETCH is ignored.
- status is sampled only in EXEC, and only for CBZ/CBNZ.

## Configuration
- LEGV8_CTRL_BRANCH_EN defined: B (opcode 000101), CBZ (10110100) and CBNZ (10110101) are decoded. Offsets are sext(br26) or sext(cb19).
- Undefined: these opcodes are unsupported and enter HALT. Branch logic and status sampling are absent, and pc always advances by 4.

## Structure
- Package legv8_ctrl_pkg holds:
  - opcode constants (11-bit R/D, 10-bit I, 9-bit MOVZ, 8-bit CB, 6-bit B);
  - FS codes;
  - the state enum;
  - ControlWord field offsets and the XZR index (31).
- Sub-module legv8_decoder: combinational; IR in, {ControlWord, constant, is_branch, is_cond, cond_nz, illegal} out.
- The top holds the FSM, pc, IR and output registers.

## Test plan
- Reset then ADDI X1,XZR,#5 (32'h910017E1), ack in first FETCH cycle → in EXEC: ControlWord SA=31, DA=1, Bsel=1, EN_ALU=1, RegWrite=1, FS=01000, constant=5; pc 0→4 after 3 cycles.
- LDUR X2,[X1,#-8] → constant=64'hFFFF_FFFF_FFFF_FFF8, EN_Mem=1, EN_ALU=0, DA=2.
- STUR X2,[X1,#0] → MemWrite=1, SB=2, RegWrite=0, both enables 0.
- CBZ X3,+3 at pc=0x10 with status[0]=1 → pc=0x1C; with status[0]=0 → pc=0x14; B −1 at pc=0 → pc=64'hFFFF_FFFF_FFFF_FFFC.
- imem_ack delayed 4 cycles, then reset asserted in the 2nd wait cycle → pc=RESET_PC, ControlWord=0, FETCH restarts.
- Instruction 32'h0 → halted=1, imem_req=0 thereafter; acks ignored until reset. Without LEGV8_CTRL_BRANCH_EN, a CBZ also halts.
